// File: rtl/puertos_pkg.sv
// Shared constants for the PicoBlaze input-port block: port addresses and
// status-register bit positions.
package puertos_pkg;

  localparam logic [7:0] PUERTO_ESTADO      = 8'h01;
  localparam logic [7:0] PUERTO_DATO        = 8'h02;
  localparam logic [7:0] PUERTO_EVENTO      = 8'h04;
  localparam logic [7:0] PUERTO_BOTONES     = 8'h05;
  localparam logic [7:0] PUERTO_BUFFER_BASE = 8'h10;

  // Bit positions inside ESTADO
  localparam int EST_INICIO  = 0;
  localparam int EST_ESCRIBE = 1;
  localparam int EST_LEE     = 2;
  localparam int EST_W       = 3;

endpackage

// File: rtl/sincroniza_flanco.sv
// Two-flop synchronizer for one asynchronous button level, followed by an
// extra register so a single-cycle pulse marks each synchronized rising edge.
module sincroniza_flanco (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic nivel_o,
  output logic flanco_o
);

  logic meta_q;
  logic sinc_q;
  logic previo_q;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sinc_q   <= 1'b0;
      previo_q <= 1'b0;
    end else begin
      meta_q   <= async_i;
      sinc_q   <= meta_q;
      previo_q <= sinc_q;
    end
  end

  assign nivel_o  = sinc_q;
  assign flanco_o = sinc_q & ~previo_q;

endmodule

// File: rtl/puertos_de_entrada.sv
// Read-side port decoder for PicoBlaze: muxes peripheral data onto In_Port,
// keeps sticky clear-on-read status/button flags, buffers the bytes of the
// RTC read sequence and drives the interrupt request.
module puertos_de_entrada
  import puertos_pkg::*;
#(
  parameter int         N_REGISTROS = 9,
  parameter int         N_BOTONES   = 5,
  parameter logic [7:0] INT_MASK    = 8'h07
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Read_Strobe,
  input  logic [7:0]           Port_ID,
  output logic [7:0]           In_Port,
  input  logic                 fin_inicio,
  input  logic                 fin_escribe,
  input  logic                 fin_lee,
  input  logic [7:0]           DATO_LEIDO,
  input  logic                 dato_valido,
  input  logic [3:0]           secuencia_lectura,
  input  logic [N_BOTONES-1:0] botones,
  output logic                 interrupt,
  input  logic                 interrupt_ack
);

  logic [N_BOTONES-1:0] nivel;
  logic [N_BOTONES-1:0] flanco;

  logic [EST_W-1:0]     estado_q, estado_d, estado_set;
  logic [N_BOTONES-1:0] evento_q, evento_d;
  logic [7:0]           dato_ultimo_q;
  logic [7:0]           buffer_q [N_REGISTROS];
  logic [7:0]           in_port_q, in_port_d;
  logic                 interrupt_q, interrupt_d;
  logic                 nuevo_evento;

  genvar g;
  generate
    for (g = 0; g < N_BOTONES; g++) begin : g_boton
      sincroniza_flanco u_sinc (
        .clk      (clk),
        .reset    (reset),
        .async_i  (botones[g]),
        .nivel_o  (nivel[g]),
        .flanco_o (flanco[g])
      );
    end
  endgenerate

  // Flag next-state: a set in the same cycle as a read-clear survives
  always_comb begin
    estado_set = '0;
    estado_set[EST_INICIO]  = fin_inicio;
    estado_set[EST_ESCRIBE] = fin_escribe;
    estado_set[EST_LEE]     = fin_lee;

    estado_d = estado_q;
    if (Read_Strobe && (Port_ID == PUERTO_ESTADO)) estado_d = '0;
    estado_d = estado_d | estado_set;

    evento_d = evento_q;
    if (Read_Strobe && (Port_ID == PUERTO_EVENTO)) evento_d = '0;
    evento_d = evento_d | flanco;

    nuevo_evento = (|(estado_set & INT_MASK[EST_W-1:0])) | (|flanco);
    interrupt_d  = nuevo_evento | (interrupt_q & ~interrupt_ack);
  end

  // Read multiplexer; unmapped addresses return zero
  always_comb begin
    in_port_d = 8'h00;
    case (Port_ID)
      PUERTO_ESTADO:  in_port_d = 8'(estado_q);
      PUERTO_DATO:    in_port_d = dato_ultimo_q;
      PUERTO_EVENTO:  in_port_d = 8'(evento_q);
      PUERTO_BOTONES: in_port_d = 8'(nivel);
      default: begin
        for (int i = 0; i < N_REGISTROS; i++) begin
          if (Port_ID == (PUERTO_BUFFER_BASE + 8'(i))) in_port_d = buffer_q[i];
        end
      end
    endcase
  end

  // Control registers: flags, interrupt request and registered read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= '0;
      evento_q    <= '0;
      interrupt_q <= 1'b0;
      in_port_q   <= 8'h00;
    end else begin
      estado_q    <= estado_d;
      evento_q    <= evento_d;
      interrupt_q <= interrupt_d;
      in_port_q   <= in_port_d;
    end
  end

  // RTC read buffer; out-of-range indices only update the last-byte register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dato_ultimo_q <= 8'h00;
      for (int i = 0; i < N_REGISTROS; i++) buffer_q[i] <= 8'h00;
    end else if (dato_valido) begin
      dato_ultimo_q <= DATO_LEIDO;
      for (int i = 0; i < N_REGISTROS; i++) begin
        if (secuencia_lectura == 4'(i)) buffer_q[i] <= DATO_LEIDO;
      end
    end
  end

  assign In_Port   = in_port_q;
  assign interrupt = interrupt_q;

endmodule

// File: tb/tb_puertos_de_entrada.sv
// Self-checking bench for puertos_de_entrada: directed scenarios plus a
// randomized run against a behavioural model of the port map.
module tb_puertos_de_entrada;

  localparam int NR = 9;
  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          Read_Strobe;
  logic [7:0]    Port_ID;
  logic [7:0]    In_Port;
  logic          fin_inicio, fin_escribe, fin_lee;
  logic [7:0]    DATO_LEIDO;
  logic          dato_valido;
  logic [3:0]    secuencia_lectura;
  logic [NB-1:0] botones;
  logic          interrupt;
  logic          interrupt_ack;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // behavioural model state for the randomized run
  logic [2:0] m_estado;
  logic [7:0] m_ultimo;
  logic [7:0] m_buf [NR];
  logic       m_int;

  puertos_de_entrada #(.N_REGISTROS(NR), .N_BOTONES(NB), .INT_MASK(8'h07)) dut (
    .clk               (clk),
    .reset             (reset),
    .Read_Strobe       (Read_Strobe),
    .Port_ID           (Port_ID),
    .In_Port           (In_Port),
    .fin_inicio        (fin_inicio),
    .fin_escribe       (fin_escribe),
    .fin_lee           (fin_lee),
    .DATO_LEIDO        (DATO_LEIDO),
    .dato_valido       (dato_valido),
    .secuencia_lectura (secuencia_lectura),
    .botones           (botones),
    .interrupt         (interrupt),
    .interrupt_ack     (interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Reads one port: present address, one edge, compare
  task automatic read_port(input logic [7:0] pid, input logic [7:0] exp, input string name);
    Port_ID = pid;
    tick();
    total_cnt++;
    if (In_Port !== exp)
      $display("FAIL %s port=%02h got=%02h expected=%02h", name, pid, In_Port, exp);
    else pass_cnt++;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] pid);
    if (pid == 8'h01) return {5'b0, m_estado};
    if (pid == 8'h02) return m_ultimo;
    if (pid == 8'h04) return 8'h00;
    if (pid == 8'h05) return 8'h00;
    if (pid >= 8'h10 && pid < 8'h10 + NR) return m_buf[pid - 8'h10];
    return 8'h00;
  endfunction

  task automatic idle_inputs();
    Read_Strobe = 0; Port_ID = 8'h00; fin_inicio = 0; fin_escribe = 0; fin_lee = 0;
    DATO_LEIDO = 8'h00; dato_valido = 0; secuencia_lectura = 4'h0; interrupt_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    botones = '0;
    reset = 1;
    #3;
    total_cnt++;
    if (In_Port !== 8'h00) $display("FAIL reset_in_port got=%02h expected=00", In_Port);
    else pass_cnt++;
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL reset_interrupt got=%b expected=0", interrupt);
    else pass_cnt++;
    tick_n(2);
    reset = 0;
    read_port(8'h01, 8'h00, "post_reset_estado");
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL post_reset_interrupt got=%b expected=0", interrupt);
    else pass_cnt++;
  endtask

  task automatic test_estado();
    fin_escribe = 1; tick(); fin_escribe = 0;
    read_port(8'h01, 8'h02, "estado_escribe");
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL int_after_escribe got=%b expected=1", interrupt);
    else pass_cnt++;
    interrupt_ack = 1; tick(); interrupt_ack = 0;
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL int_after_ack got=%b expected=0", interrupt);
    else pass_cnt++;
    read_port(8'h01, 8'h02, "estado_kept_after_ack");
    Read_Strobe = 1; tick(); Read_Strobe = 0;
    read_port(8'h01, 8'h00, "estado_cleared");
  endtask

  task automatic test_buffer();
    for (int i = 0; i < NR; i++) begin
      dato_valido = 1; secuencia_lectura = 4'(i); DATO_LEIDO = 8'h30 + 8'(i);
      tick();
    end
    dato_valido = 0;
    for (int i = 0; i < NR; i++) read_port(8'h10 + 8'(i), 8'h30 + 8'(i), "buffer_fill");
    read_port(8'h02, 8'h38, "dato_ultimo");
    dato_valido = 1; secuencia_lectura = 4'hF; DATO_LEIDO = 8'hAA; tick(); dato_valido = 0;
    read_port(8'h02, 8'hAA, "dato_ultimo_idx_f");
    for (int i = 0; i < NR; i++) read_port(8'h10 + 8'(i), 8'h30 + 8'(i), "buffer_unchanged");
    read_port(8'h10 + 8'(NR), 8'h00, "past_buffer_end");
  endtask

  task automatic test_set_wins();
    Port_ID = 8'h01; Read_Strobe = 1; fin_lee = 1; tick();
    Read_Strobe = 0; fin_lee = 0;
    read_port(8'h01, 8'h04, "set_beats_clear");
    // ack and new event together: interrupt must stay high
    interrupt_ack = 1; fin_inicio = 1; tick(); interrupt_ack = 0; fin_inicio = 0;
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL ack_with_event got=%b expected=1", interrupt);
    else pass_cnt++;
    read_port(8'h01, 8'h05, "simultaneous_flags");
    Read_Strobe = 1; interrupt_ack = 1; tick(); Read_Strobe = 0; interrupt_ack = 0;
  endtask

  task automatic test_botones();
    botones = 5'b01000;
    tick_n(4);
    read_port(8'h04, 8'h08, "evento_boton3");
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL int_after_boton got=%b expected=1", interrupt);
    else pass_cnt++;
    read_port(8'h05, 8'h08, "nivel_boton3");
    Port_ID = 8'h04; Read_Strobe = 1; tick(); Read_Strobe = 0;
    read_port(8'h04, 8'h00, "evento_cleared_held");
    botones = '0; tick_n(4);
    read_port(8'h05, 8'h00, "nivel_released");
    botones = 5'b01000; tick_n(4);
    read_port(8'h04, 8'h08, "evento_repress");
    Port_ID = 8'h04; Read_Strobe = 1; interrupt_ack = 1; tick();
    Read_Strobe = 0; interrupt_ack = 0;
    botones = '0; tick_n(4);
  endtask

  task automatic test_random();
    logic [7:0] exp_in;
    logic [2:0] set;
    reset = 1; #2; reset = 0;
    m_estado = '0; m_ultimo = '0; m_int = 0;
    for (int i = 0; i < NR; i++) m_buf[i] = '0;
    for (int c = 0; c < 300; c++) begin
      case ($urandom_range(0, 5))
        0: Port_ID = 8'h01;
        1: Port_ID = 8'h02;
        2: Port_ID = 8'h04;
        3: Port_ID = 8'h05;
        4: Port_ID = 8'h10 + 8'($urandom_range(0, 10));
        default: Port_ID = 8'($urandom);
      endcase
      Read_Strobe   = ($urandom_range(0, 3) == 0);
      fin_inicio    = ($urandom_range(0, 7) == 0);
      fin_escribe   = ($urandom_range(0, 7) == 0);
      fin_lee       = ($urandom_range(0, 7) == 0);
      interrupt_ack = ($urandom_range(0, 3) == 0);
      dato_valido   = ($urandom_range(0, 2) == 0);
      secuencia_lectura = 4'($urandom_range(0, 15));
      DATO_LEIDO    = 8'($urandom);
      // model: read returns pre-edge state, then apply this cycle's updates
      exp_in = model_read(Port_ID);
      set = {fin_lee, fin_escribe, fin_inicio};
      if (Read_Strobe && Port_ID == 8'h01) m_estado = 3'b000;
      m_estado = m_estado | set;
      m_int = (set != 3'b000) || (m_int && !interrupt_ack);
      if (dato_valido) begin
        m_ultimo = DATO_LEIDO;
        if (int'(secuencia_lectura) < NR) m_buf[secuencia_lectura] = DATO_LEIDO;
      end
      tick();
      total_cnt++;
      if (In_Port !== exp_in)
        $display("FAIL rand_in_port cyc=%0d got=%02h expected=%02h", c, In_Port, exp_in);
      else pass_cnt++;
      total_cnt++;
      if (interrupt !== m_int)
        $display("FAIL rand_interrupt cyc=%0d got=%b expected=%b", c, interrupt, m_int);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NR; i++) begin
      dato_valido = 1; secuencia_lectura = 4'(i); DATO_LEIDO = 8'hC0 + 8'(i);
      tick();
    end
    dato_valido = 0;
    fin_inicio = 1; tick(); fin_inicio = 0;
    botones = 5'b00001; tick_n(3);
    read_port(8'h10, 8'hC0, "pre_reset_buffer");
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL pre_reset_interrupt got=%b expected=1", interrupt);
    else pass_cnt++;
    #2 reset = 1; botones = '0;
    #1;
    total_cnt++;
    if (In_Port !== 8'h00) $display("FAIL async_reset_in_port got=%02h expected=00", In_Port);
    else pass_cnt++;
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL async_reset_interrupt got=%b expected=0", interrupt);
    else pass_cnt++;
    tick();
    reset = 0;
    read_port(8'h01, 8'h00, "after_reset_estado");
    read_port(8'h02, 8'h00, "after_reset_dato");
    read_port(8'h04, 8'h00, "after_reset_evento");
    read_port(8'h05, 8'h00, "after_reset_nivel");
    for (int i = 0; i < NR; i++) read_port(8'h10 + 8'(i), 8'h00, "after_reset_buffer");
  endtask

  initial begin
    test_reset();
    test_estado();
    test_buffer();
    test_set_wins();
    test_botones();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
